// File: rtl/data_sram_bridge.sv
// Bridges the memory stage's single-cycle SRAM access to a req/addr_ok/data_ok bus,
// stalling the pipeline until the (single outstanding) transaction completes.
module data_sram_bridge #(
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        flush,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    // state | meaning
    // IDLE  | no access in flight, captures a new mem_en
    // REQ   | bus_req asserted, waiting for addr_ok
    // WAIT  | request accepted, waiting for data_ok
    // DONE  | one-cycle completion, pipeline advances
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        cancel;
    logic [31:0] addr_xlat;
    logic        complete;
    logic        cancel_now;

    always_comb begin
        addr_xlat = mem_addr;
        if (KSEG_MAP && mem_addr[31:30] == 2'b10)
            addr_xlat = {3'b000, mem_addr[28:0]};
    end

    assign stall      = mem_en && (state != DONE);
    assign complete   = ((state == REQ) && bus_addr_ok && bus_data_ok) ||
                        ((state == WAIT) && bus_data_ok);
    // a flush coinciding with completion discards that result too
    assign cancel_now = cancel || flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cancel    <= 1'b0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_wstrb <= 4'b0;
            bus_addr  <= 32'b0;
            bus_wdata <= 32'b0;
            mem_rdata <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en && !flush) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= |mem_wen;
                        bus_wstrb <= mem_wen;
                        bus_addr  <= addr_xlat;
                        bus_wdata <= mem_wdata;
                        state     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (state == REQ && bus_addr_ok)
                        bus_req <= 1'b0;
                    if (complete) begin
                        cancel <= 1'b0;
                        if (cancel_now) begin
                            state <= IDLE;
                        end else begin
                            state <= DONE;
                            if (!bus_wr)
                                mem_rdata <= bus_rdata;
                        end
                    end else begin
                        if (flush)
                            cancel <= 1'b1;
                        if (state == REQ && bus_addr_ok)
                            state <= WAIT;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Sits directly downstream of the memory stage. Converts the stage's single-cycle SRAM-style access (`mem_en`/`mem_wen`/`mem_addr`/`mem_wdata`/`mem_rdata`) into a request/accept/data handshake toward the data bus. Holds the pipeline with `stall` until the access completes. Applies fixed kseg0/kseg1 address translation and supports one outstanding transaction, including flush-cancelled accesses.

## Interface
- `KSEG_MAP`, default 1: when 1 and `mem_addr[31:30]==2'b10`, the bus address is `{3'b000, mem_addr[28:0]}`; otherwise the address passes through unchanged.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mem_en`  in  1  access request from the memory stage. It is already suppressed on alignment error.
- `mem_wen`  in  4  byte write enables; 0 means a read.
- `mem_addr`  in  32  virtual byte address.
- `mem_wdata`  in  32  write data, already lane-replicated by the memory stage.
- `mem_rdata`  out  32  read data returned to the memory stage.
- `flush`  in  1  exception/redirect; the current access result must be discarded.
- `stall`  out  1  freezes the memory stage and everything upstream.
- `bus_req`  out  1  request valid.
- `bus_wr`  out  1  1 = write.
- `bus_wstrb`  out  4  byte strobes (equal to the captured `mem_wen`).
- `bus_addr`  out  32  translated address.
- `bus_wdata`  out  32  write data.
- `bus_addr_ok`  in  1  request accepted this cycle (valid only while `bus_req`=1).
- `bus_data_ok`  in  1  read data valid or write response this cycle.
- `bus_rdata`  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE. A `cancel` flag is held alongside the state.
- IDLE, `mem_en`=1, `flush`=0:
  - Capture `wr=|mem_wen`, strobes, translated address and wdata into registers.
  - Go to REQ.
  - If `flush`=1, capture nothing and stay in IDLE.
- REQ:
  - Drive `bus_req`=1 with the captured fields.
  - The fields are held unchanged until `bus_addr_ok`.
  - On `bus_addr_ok`: if `bus_data_ok` is also 1 in the same cycle, go to DONE; otherwise go to WAIT.
- WAIT:
  - `bus_req`=0.
  - On `bus_data_ok`, go to DONE.
- Read data capture: whenever `bus_data_ok` is accepted, latch `bus_rdata` into the `mem_rdata` register if `wr`=0. Writes leave `mem_rdata` unchanged.
- DONE: lasts exactly one cycle, then go to IDLE.
- Cancelled completion: if `cancel`=1 when the completion arrives, go straight to IDLE instead of DONE. `mem_rdata` is not updated. Clear `cancel`.
- `cancel` is set by `flush`=1 in REQ or WAIT. A request already presented is never withdrawn; the bus transaction always runs to completion.
- Flush in DONE has no effect; the state still returns to IDLE.
- `stall` (combinational) = `mem_en` && !(state==DONE).
  - During a cancelled access, a new `mem_en` from the redirected stream stalls until the bridge returns to IDLE.
  - The new access is then captured on the IDLE cycle.
- Back-to-back accesses: in DONE the pipeline advances. The next instruction's `mem_en` is captured in the following IDLE cycle, so the minimum gap between bus requests is 2 cycles.
- Reset values: state IDLE, `cancel` 0, `bus_req` 0, `bus_wr` 0, `bus_wstrb` 0, `bus_addr` 0, `bus_wdata` 0, `mem_rdata` 0. `stall` follows its equation.

## Timing
- Cycle 0: IDLE with `mem_en`; `stall`=1.
- Cycle 1: `bus_req`=1.
- Best case: `addr_ok` and `data_ok` both arrive in cycle 1. Cycle 2 is DONE with `stall`=0 and `mem_rdata` valid, giving 2 stall cycles.
- Each extra cycle before `addr_ok` or `data_ok` adds one stall cycle.
- `mem_rdata` is registered: valid throughout DONE and held until the next non-cancelled read completes.
- `bus_*` outputs come from registers only, with no combinational path from `mem_*`.
- `bus_data_ok` is ignored in IDLE, REQ (before `addr_ok`) and DONE.
- Reset mid-transaction: the bridge returns to IDLE immediately and drops `bus_req`. The bus side is reset by the same `rst`.

## Test plan
- **Read, zero wait:** `mem_addr`=0x8000_1004, `mem_wen`=0; bus returns `addr_ok`+`data_ok` on the first REQ cycle with `bus_rdata`=0xDEAD_BEEF. Expect `bus_addr`=0x0000_1004, `bus_wr`=0, `stall`=1 for 2 cycles, and `mem_rdata`=0xDEAD_BEEF in DONE.
- **Byte write, delayed bus:** `mem_addr`=0xA000_0012, `mem_wen`=4'b0100, `mem_wdata`=0x5A5A_5A5A; `addr_ok` after 3 cycles, `data_ok` 2 cycles later. Expect `bus_addr`=0x0000_0012, `bus_wstrb`=4'b0100, request held stable 3 cycles, `stall`=1 for 6 cycles, and `mem_rdata` unchanged.
- **KSEG_MAP off/kuseg:** with `KSEG_MAP`=0, address 0x8000_0000 passes through. With `KSEG_MAP`=1, address 0x0040_0000 passes through unchanged.
- **Flush in WAIT:** read issued, `flush` pulsed in WAIT, `data_ok` arrives with 0x1234_5678. Expect no DONE cycle, previous `mem_rdata` retained, and state IDLE the following cycle.
- **Flush plus new access:** new `mem_en` (redirected stream) arrives while the cancelled access is outstanding. Expect `stall`=1 until the old `data_ok` completes, then a new capture in IDLE and a second `bus_req`.
- **Async reset while `bus_req`=1:** expect `bus_req`=0 and IDLE before the next clock edge, and all registered outputs zero.
